// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sharing of one I2C master engine between NREQ requesters.
// Define I2C_ARB_TIMEOUT_EN to abort a transfer whose m_done never arrives within TIMEOUT_CYC cycles.
module i2c_req_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 400000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_op,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   req_gnt,
    output logic [NREQ-1:0]   req_done,
    output logic [NREQ-1:0]   req_err,
    output logic [7:0]        rdata,
    output logic              m_newd,
    output logic              m_op,
    output logic [6:0]        m_addr,
    output logic [7:0]        m_din,
    input  logic [7:0]        m_dout,
    input  logic              m_busy,
    input  logic              m_ack_err,
    input  logic              m_done,
    output logic              timeout
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, RESP, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d, idx_q, idx_d, pick;
    logic            op_q, op_d, err_q, err_d;
    logic [6:0]      addr_q, addr_d;
    logic [7:0]      din_q, din_d, rdata_q, rdata_d;
    logic [NREQ-1:0] onehot;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            to_q, to_d;
`endif

    // Scan downward so the requester closest to rr_q is the last (winning) assignment.
    always_comb begin
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(rr_q) + k) % NREQ]) pick = IW'((int'(rr_q) + k) % NREQ);
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        idx_d   = idx_q;
        op_d    = op_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = to_q;
`endif
        case (state_q)
            IDLE: if (|req) begin
                state_d = GRANT;
                idx_d   = pick;
                op_d    = req_op[pick];
                addr_d  = req_addr[7*int'(pick) +: 7];
                din_d   = req_wdata[8*int'(pick) +: 8];
            end
            GRANT: if (!m_busy) state_d = ISSUE;
            ISSUE: begin
                state_d = WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                cnt_d   = CW'(TIMEOUT_CYC);
`endif
            end
            WAIT: if (m_done) begin
                state_d = RESP;
                rdata_d = op_q ? m_dout : rdata_q;
                err_d   = m_ack_err;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(1)) begin
                state_d = RESP;
                rdata_d = 8'h00;
                err_d   = 1'b1;
                to_d    = 1'b1;
            end else cnt_d = cnt_q - 1'b1;
`endif
            RESP: begin
                state_d = RELEASE;
                rr_d    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            idx_q   <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign onehot   = NREQ'(1) << idx_q;
    assign req_gnt  = (state_q inside {GRANT, ISSUE, WAIT}) ? onehot : '0;
    assign req_done = (state_q == RESP) ? onehot : '0;
    assign req_err  = (state_q == RESP && err_q) ? onehot : '0;
    assign m_newd   = state_q == ISSUE;
    assign m_op     = op_q;
    assign m_addr   = addr_q;
    assign m_din    = din_q;
    assign rdata    = rdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
    assign timeout  = to_q;
`else
    assign timeout  = 1'b0 && (TIMEOUT_CYC > 0);
`endif
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: randomized and directed checks of i2c_req_arbiter against a transaction-level model.
module tb_i2c_req_arbiter;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0, req_op = '0;
    logic [7*N-1:0] req_addr = '0;
    logic [8*N-1:0] req_wdata = '0;
    logic [N-1:0]  req_gnt, req_done, req_err;
    logic [7:0]    rdata, m_din;
    logic          m_newd, m_op, timeout;
    logic [6:0]    m_addr;
    logic [7:0]    m_dout = '0;
    logic          m_busy = 1'b0, m_ack_err = 1'b0, m_done = 1'b0;

    int total = 0, bad = 0;
    int exp_ptr = 0, exp_newd = 0, newd_cnt = 0, viol = 0;
    logic [7:0] exp_rdata = '0;

    i2c_req_arbiter #(.NREQ(N), .TIMEOUT_CYC(20)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_gnt(req_gnt), .req_done(req_done), .req_err(req_err),
        .rdata(rdata), .m_newd(m_newd), .m_op(m_op), .m_addr(m_addr), .m_din(m_din),
        .m_dout(m_dout), .m_busy(m_busy), .m_ack_err(m_ack_err), .m_done(m_done),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!$onehot0(req_gnt)) viol++;
        if (m_newd) newd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_model(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic serve(input int busy_cyc, input int done_dly, input logic [7:0] dout,
                         input logic ack, input logic keep, input logic drop_early,
                         output logic [N-1:0] g, output int lat);
        int w;
        logic op;
        logic [6:0] a;
        logic [7:0] d;
        w  = pick_model(req, exp_ptr);
        op = req_op[w];
        a  = req_addr[7*w +: 7];
        d  = req_wdata[8*w +: 8];
        m_busy = busy_cyc > 0;
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (req_gnt != 0) break;
        end
        g = req_gnt;
        chk("gnt", 32'(req_gnt), 32'(1) << w);
        for (int i = 0; i < busy_cyc; i++) begin
            m_done = (i == 1);
            chk("newd_while_busy", 32'(m_newd), 32'd0);
            tick();
        end
        m_done = 1'b0;
        m_busy = 1'b0;
        tick();
        chk("newd", 32'(m_newd), 32'd1);
        chk("m_op", 32'(m_op), 32'(op));
        chk("m_addr", 32'(m_addr), 32'(a));
        chk("m_din", 32'(m_din), 32'(d));
        tick();
        chk("newd_once", 32'(m_newd), 32'd0);
        chk("gnt_wait", 32'(req_gnt), 32'(1) << w);
        m_busy = 1'b1;
        if (drop_early) req[w] = 1'b0;
        for (int i = 0; i < done_dly; i++) begin
            chk("done_early", 32'(req_done), 32'd0);
            tick();
        end
        m_dout = dout;
        m_ack_err = ack;
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        m_busy = 1'b0;
        m_dout = 8'($urandom);
        m_ack_err = 1'b0;
        if (op) exp_rdata = dout;
        chk("done", 32'(req_done), 32'(1) << w);
        chk("err", 32'(req_err), 32'(ack) << w);
        chk("rdata", 32'(rdata), 32'(exp_rdata));
        chk("gnt_resp", 32'(req_gnt), 32'd0);
        exp_ptr = (w + 1) % N;
        exp_newd++;
        if (!keep) req[w] = 1'b0;
        tick();
        chk("done_pulse", 32'(req_done), 32'd0);
    endtask

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] order [5];
        int lat, n, w;
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        #2 rst = 1'b0;
        #3;
        chk("rst_a", 32'({req_gnt, req_done, req_err, rdata}), 32'd0);
        chk("rst_b", 32'({m_newd, m_op, m_addr, m_din, timeout}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // all four held high: strict rotation 0,1,2,3,0
        req_op = 4'b0000;
        req_addr = 28'($urandom);
        req_wdata = $urandom;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve(0, $urandom_range(0, 5), 8'($urandom), 1'b0, 1'b1, 1'b0, g, lat);
            chk("rr_order", 32'(g), 32'(order[i]));
        end
        req = '0;
        tick();

        req_op[0] = 1'b0;
        req_addr[6:0] = 7'h50;
        req_wdata[7:0] = 8'hA5;
        req = 4'b0001;
        serve(0, 100, 8'h77, 1'b0, 1'b0, 1'b0, g, lat);
        chk("gnt_latency", 32'(lat), 32'd1);

        req_op[2] = 1'b1;
        req = 4'b0100;
        serve(0, 10, 8'h3C, 1'b0, 1'b0, 1'b0, g, lat);
        chk("read_rdata", 32'(rdata), 32'h3C);

        req = 4'b0010;
        serve(50, 20, 8'($urandom), 1'b1, 1'b0, 1'b0, g, lat);

        // reset while the master is mid-transfer
        req = 4'b0001;
        for (n = 0; n < 20 && req_gnt == 0; n++) tick();
        tick();
        tick();
        exp_newd++;
        m_busy = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_a", 32'({req_gnt, req_done, req_err, rdata}), 32'd0);
        chk("rst_mid_b", 32'({m_newd, m_op, m_addr, m_din, timeout}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        exp_ptr = 0;
        exp_rdata = 8'h00;
        req = 4'b0010;
        serve(5, 8, 8'($urandom), 1'b0, 1'b0, 1'b0, g, lat);

`ifdef I2C_ARB_TIMEOUT_EN
        req_op = 4'b1111;
        req = 4'b0100;
        w = pick_model(req, exp_ptr);
        for (n = 0; n < 20 && req_gnt == 0; n++) tick();
        tick();
        tick();
        n = 0;
        while (req_done == 0 && n < 40) begin
            tick();
            n++;
        end
        chk("to_cycles", 32'(n), 32'd20);
        chk("to_done", 32'(req_done), 32'(1) << w);
        chk("to_err", 32'(req_err), 32'(1) << w);
        chk("to_rdata", 32'(rdata), 32'd0);
        chk("to_flag", 32'(timeout), 32'd1);
        exp_rdata = 8'h00;
        exp_ptr = (w + 1) % N;
        exp_newd++;
        req = '0;
        tick();
`endif

        for (int r = 0; r < 30; r++) begin
            req_op = 4'($urandom);
            req_addr = 28'($urandom);
            req_wdata = $urandom;
            req = 4'($urandom_range(1, 15));
            serve(($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0, $urandom_range(0, 15),
                  8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), g, lat);
        end

        tick();
        chk("gnt_onehot0", 32'(viol), 32'd0);
        chk("newd_count", 32'(newd_cnt), 32'(exp_newd));
`ifdef I2C_ARB_TIMEOUT_EN
        chk("timeout_sticky", 32'(timeout), 32'd1);
`else
        chk("timeout_tied", 32'(timeout), 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares a single I2C master engine between NREQ independent requesters, such as the register-config FSM, the sensor poller and the debug port.
- Arbitrates round-robin and latches the winner's command (op, 7-bit address, write byte).
- Issues the command to the master with a one-cycle newd pulse, waits for the master's done, then returns read data and ack status to the winner.
- Sits between the requesters and the i2c_master instance in the I2C subsystem top.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 400000, cycles to wait for m_done before declaring timeout (10 ms at 40 MHz); used only with the optional feature

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester request, level, held until req_done
req_op  in  NREQ  per-requester op: 1 = read, 0 = write
req_addr  in  7*NREQ  packed slave addresses, requester i at [7i+6:7i]
req_wdata  in  8*NREQ  packed write bytes, requester i at [8i+7:8i]
req_gnt  out  NREQ  one-hot grant, high from GRANT until RESP
req_done  out  NREQ  one-cycle completion pulse to the winner
req_err  out  NREQ  error status, valid with req_done
rdata  out  8  read byte, valid with req_done, held until next completion
m_newd  out  1  one-cycle start pulse to master
m_op  out  1  latched op
m_addr  out  7  latched address
m_din  out  8  latched write byte
m_dout  in  8  master read data
m_busy  in  1  master busy
m_ack_err  in  1  master ack error
m_done  in  1  master done pulse
timeout  out  1  sticky timeout flag, cleared by reset only

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: req_gnt, req_done, req_err, rdata, m_newd, m_op, m_addr, m_din, timeout.
- States: IDLE, GRANT, ISSUE, WAIT, RESP, RELEASE.
- IDLE: if |req, pick the first asserted requester scanning upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ... NREQ-1, 0, ...).
  - Latch index, op, addr and wdata into m_op/m_addr/m_din.
  - Set req_gnt[idx]=1; go to GRANT.
- GRANT: wait until m_busy==0, then go to ISSUE. This covers reset mid-operation while the master is still transferring.
- ISSUE: m_newd=1 for exactly one cycle; go to WAIT.
- WAIT: on m_done=1, latch rdata = m_op ? m_dout : rdata(unchanged) and err = m_ack_err; go to RESP.
- RESP:
  - req_done[idx]=1 and req_err[idx]=err for one cycle.
  - req_gnt cleared; rr_ptr = (idx+1) mod NREQ; go to RELEASE.
- RELEASE: one cycle; all req inputs ignored so the winner can drop req; go to IDLE.
- Latency:
  - req rising in IDLE at cycle 0 → req_gnt at cycle 1.
  - m_newd at cycle 2 if the master is idle.
  - req_done 1 cycle after m_done.
- Boundary rules:
  - m_done outside WAIT is ignored.
  - The winner dropping req before completion is ignored; the transaction completes and req_done still pulses.
  - Request inputs other than the latched copies may change freely after GRANT.
  - Only one transaction is ever outstanding.
  - With a single requester continuously asserting, back-to-back service gap is 2 cycles (RESP, RELEASE) plus master time.
  - A requester that keeps req high after req_done is re-served only after all other pending requesters (round-robin fairness).

Optional Feature:
- Macro I2C_ARB_TIMEOUT_EN.
- When defined:
  - A down-counter loads TIMEOUT_CYC on entry to WAIT and decrements each cycle.
  - On reaching 0 without m_done, go to RESP with err=1, rdata forced to 8'h00, timeout=1 (sticky).
  - If m_done and expiry occur in the same cycle, m_done wins.
- When undefined: no counter; WAIT lasts until m_done; timeout is tied 0.

Test Plan:
- Single write: req[0]=1, op=0, addr=7'h50, wdata=8'hA5, master done after 100 cycles, ack_err=0 → m_newd one pulse with m_addr=50, m_din=A5; req_done[0] pulse; req_err[0]=0.
- Read: req[2]=1, op=1, m_dout=8'h3C at m_done → rdata=3C with req_done[2]; req_gnt[2] high GRANT..WAIT only.
- Round-robin: req[3:0]=4'b1111 held high → grant order 0,1,2,3,0; exactly one m_newd per grant; never two grants high.
- NACK plus busy: m_busy=1 at grant for 50 cycles → m_newd delayed until m_busy=0; m_ack_err=1 → req_err=1.
- Reset mid-WAIT: drop rst for 3 cycles → all outputs 0 immediately (async); after release with m_busy still high, a new req is held in GRANT until m_busy falls.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYC=20: no m_done → req_done and req_err after 20 WAIT cycles, rdata=00, timeout=1 stays set.
